// File: rtl/mem_msgs_pkg.sv
// Memory request/response message formats shared by the processor ports and the test memories.
package mem_msgs_pkg;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

// File: rtl/test_mem_responder_pkg.sv
// Request type codes, response test codes and length decode for the behavioural test memory.
package test_mem_responder_pkg;

  localparam logic [2:0] c_mem_req_read  = 3'd0;
  localparam logic [2:0] c_mem_req_write = 3'd1;
  localparam logic [2:0] c_mem_req_init  = 3'd2;

  localparam logic [1:0] c_mem_resp_bad_type = 2'b11;

  localparam int c_cnt_w = 4;

  // A zero length field encodes a full 4-byte access.
  function automatic logic [2:0] len_to_nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 3'd4 : {1'b0, len};
  endfunction

endpackage

// File: rtl/test_mem_delay_queue.sv
// In-order response FIFO; each entry carries a countdown that must reach zero before it may leave.
module test_mem_delay_queue
  import mem_msgs_pkg::*;
  import test_mem_responder_pkg::*;
#(
  parameter int p_depth   = 4,
  parameter int p_latency = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq_val_i,
  input  mem_resp_4B_t enq_msg_i,
  output logic         full_o,
  output logic         empty_o,
  output logic         deq_val_o,
  input  logic         deq_rdy_i,
  output mem_resp_4B_t deq_msg_o
);

  localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CW = $clog2(p_depth + 1);
  localparam logic [c_cnt_w-1:0] LOAD    = c_cnt_w'(p_latency - 1);
  localparam logic [PW-1:0]      LAST    = PW'(p_depth - 1);
  localparam logic [CW-1:0]      FULLCNT = CW'(p_depth);

  mem_resp_4B_t       entry_q [p_depth];
  logic [c_cnt_w-1:0] cd_q    [p_depth];
  logic [c_cnt_w-1:0] cd_d    [p_depth];
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic               enq, deq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Full comes straight from the registered count, so a same-cycle dequeue never opens the input.
  assign full_o    = (count_q == FULLCNT);
  assign empty_o   = (count_q == '0);
  assign deq_val_o = !empty_o && (cd_q[head_q] == '0);
  assign deq_msg_o = deq_val_o ? entry_q[head_q] : '0;
  assign enq       = enq_val_i && !full_o;
  assign deq       = deq_val_o && deq_rdy_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = ptr_inc(tail_q);
    if (deq) head_d = ptr_inc(head_q);
    if (enq && !deq)      count_d = count_q + 1'b1;
    else if (!enq && deq) count_d = count_q - 1'b1;
    // Countdowns keep running under backpressure; free slots sit at zero.
    for (int i = 0; i < p_depth; i++) begin
      cd_d[i] = (cd_q[i] != '0) ? cd_q[i] - 1'b1 : cd_q[i];
      if (enq && (tail_q == PW'(i))) cd_d[i] = LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < p_depth; i++) cd_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < p_depth; i++) cd_q[i] <= cd_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !reset) entry_q[tail_q] <= enq_msg_i;
  end

endmodule

// File: rtl/test_mem_responder.sv
// Behavioural byte-addressed memory behind val/rdy request and response streams.
module test_mem_responder
  import mem_msgs_pkg::*;
  import test_mem_responder_pkg::*;
#(
  parameter int p_mem_nbytes = 65536,
  parameter int p_latency    = 1,
  parameter int p_depth      = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reqstream_val,
  output logic         reqstream_rdy,
  input  mem_req_4B_t  reqstream_msg,
  output logic         respstream_val,
  input  logic         respstream_rdy,
  output mem_resp_4B_t respstream_msg
);

  localparam int AW = $clog2(p_mem_nbytes);

  logic [7:0]   mem_q [p_mem_nbytes];
  logic [AW-1:0] byte_idx;
  logic [2:0]   nbytes;
  logic         req_go, is_read, is_write, bad_type, q_full;
  logic         unused_addr_hi, unused_q_empty;
  logic [31:0]  rd_data;
  mem_resp_4B_t resp;

  // Upper address bits are dropped so addresses wrap around the array.
  assign byte_idx       = reqstream_msg.addr[AW-1:0];
  assign unused_addr_hi = ^reqstream_msg.addr[31:AW];
  assign nbytes         = len_to_nbytes(reqstream_msg.len);
  assign is_read        = (reqstream_msg.type_ == c_mem_req_read);
  assign is_write       = (reqstream_msg.type_ == c_mem_req_write) ||
                          (reqstream_msg.type_ == c_mem_req_init);
  assign bad_type       = (reqstream_msg.type_ > c_mem_req_init);
  assign reqstream_rdy  = !q_full;
  assign req_go         = reqstream_val && reqstream_rdy && !reset;

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < nbytes) rd_data[8*k +: 8] = mem_q[byte_idx + AW'(k)];
    end
  end

  always_comb begin
    resp        = '0;
    resp.type_  = reqstream_msg.type_;
    resp.opaque = reqstream_msg.opaque;
    resp.len    = reqstream_msg.len;
    resp.test   = bad_type ? c_mem_resp_bad_type : 2'b00;
    resp.data   = is_read ? rd_data : 32'd0;
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (req_go && is_write) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nbytes) mem_q[byte_idx + AW'(k)] <= reqstream_msg.data[8*k +: 8];
      end
    end
  end

  test_mem_delay_queue #(
    .p_depth   (p_depth),
    .p_latency (p_latency)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .enq_val_i (req_go),
    .enq_msg_i (resp),
    .full_o    (q_full),
    .empty_o   (unused_q_empty),
    .deq_val_o (respstream_val),
    .deq_rdy_i (respstream_rdy),
    .deq_msg_o (respstream_msg)
  );

endmodule

// File: tb/tb_test_mem_responder.sv
// Directed bench: latency-1 instance for access decode, latency-3 instance for throughput, backpressure and reset.
module tb_test_mem_responder;
  import mem_msgs_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic aReqVal, aReqRdy, aRespVal, aRespRdy;
  logic bReqVal, bReqRdy, bRespVal, bRespRdy;
  mem_req_4B_t  aReqMsg, bReqMsg, idle;
  mem_resp_4B_t aRespMsg, bRespMsg;
  mem_resp_4B_t expQ [16];

  int total = 0;
  int bad   = 0;
  int nextIdx;

  test_mem_responder #(.p_mem_nbytes(65536), .p_latency(1), .p_depth(4)) dutA (
    .clk(clk), .reset(reset),
    .reqstream_val(aReqVal), .reqstream_rdy(aReqRdy), .reqstream_msg(aReqMsg),
    .respstream_val(aRespVal), .respstream_rdy(aRespRdy), .respstream_msg(aRespMsg)
  );

  test_mem_responder #(.p_mem_nbytes(65536), .p_latency(3), .p_depth(4)) dutB (
    .clk(clk), .reset(reset),
    .reqstream_val(bReqVal), .reqstream_rdy(bReqRdy), .reqstream_msg(bReqMsg),
    .respstream_val(bRespVal), .respstream_rdy(bRespRdy), .respstream_msg(bRespMsg)
  );

  function automatic mem_req_4B_t mkReq(input logic [2:0] t, input logic [7:0] op,
                                        input logic [31:0] addr, input logic [1:0] len,
                                        input logic [31:0] data);
    mem_req_4B_t r;
    r.type_ = t; r.opaque = op; r.addr = addr; r.len = len; r.data = data;
    return r;
  endfunction

  function automatic mem_resp_4B_t mkResp(input logic [2:0] t, input logic [7:0] op,
                                          input logic [1:0] test, input logic [1:0] len,
                                          input logic [31:0] data);
    mem_resp_4B_t r;
    r.type_ = t; r.opaque = op; r.test = test; r.len = len; r.data = data;
    return r;
  endfunction

  // Backpressure reads cycle over the eight words written at 0x3000 during the throughput run.
  function automatic mem_req_4B_t rdReq(input int i);
    return mkReq(3'd0, 8'(8'h20 + i), 32'h3000 + 32'(4 * (i % 8)), 2'd0, 32'd0);
  endfunction

  function automatic mem_resp_4B_t rdExp(input int i);
    return mkResp(3'd0, 8'(8'h20 + i), 2'd0, 2'd0, 32'hA000_0000 + 32'(i % 8));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit toB, input logic val, input mem_req_4B_t msg, input logic respRdy);
    @(posedge clk);
    #1;
    if (toB) begin
      bReqVal = val; bReqMsg = msg; bRespRdy = respRdy;
    end else begin
      aReqVal = val; aReqMsg = msg; aRespRdy = respRdy;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idle = '0;
    reset = 1'b1;
    aReqVal = 1'b0; aReqMsg = '0; aRespRdy = 1'b1;
    bReqVal = 1'b0; bReqMsg = '0; bRespRdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("a_rst_rdy", 64'(aReqRdy), 64'(1'b1));
    checkOutput("a_rst_val", 64'(aRespVal), 64'(1'b0));
    checkOutput("a_rst_msg", 64'(aRespMsg), 64'd0);
    checkOutput("b_rst_rdy", 64'(bReqRdy), 64'(1'b1));
    checkOutput("b_rst_val", 64'(bRespVal), 64'(1'b0));
    checkOutput("b_rst_msg", 64'(bRespMsg), 64'd0);

    // Write then read-after-write at latency 1.
    applyStimulus(0, 1'b1, mkReq(3'd1, 8'h05, 32'h1000, 2'd0, 32'hdeadbeef), 1'b1);
    checkOutput("basic_rdy_T", 64'(aReqRdy), 64'(1'b1));
    checkOutput("basic_val_T", 64'(aRespVal), 64'(1'b0));
    applyStimulus(0, 1'b1, mkReq(3'd0, 8'h06, 32'h1000, 2'd0, 32'd0), 1'b1);
    checkOutput("basic_val_T1", 64'(aRespVal), 64'(1'b1));
    checkOutput("basic_msg_T1", 64'(aRespMsg), 64'(mkResp(3'd1, 8'h05, 2'd0, 2'd0, 32'd0)));
    applyStimulus(0, 1'b0, idle, 1'b1);
    checkOutput("basic_val_T2", 64'(aRespVal), 64'(1'b1));
    checkOutput("basic_msg_T2", 64'(aRespMsg), 64'(mkResp(3'd0, 8'h06, 2'd0, 2'd0, 32'hdeadbeef)));
    applyStimulus(0, 1'b0, idle, 1'b1);
    checkOutput("basic_val_T3", 64'(aRespVal), 64'(1'b0));

    // Subword writes/reads, illegal type, address wrap.
    applyStimulus(0, 1'b1, mkReq(3'd1, 8'h01, 32'h2000, 2'd0, 32'h11223344), 1'b1);
    applyStimulus(0, 1'b1, mkReq(3'd1, 8'h02, 32'h2001, 2'd1, 32'h000000ab), 1'b1);
    checkOutput("sub_w1", 64'(aRespMsg), 64'(mkResp(3'd1, 8'h01, 2'd0, 2'd0, 32'd0)));
    applyStimulus(0, 1'b1, mkReq(3'd0, 8'h03, 32'h2000, 2'd0, 32'd0), 1'b1);
    checkOutput("sub_w2", 64'(aRespMsg), 64'(mkResp(3'd1, 8'h02, 2'd0, 2'd1, 32'd0)));
    applyStimulus(0, 1'b1, mkReq(3'd0, 8'h04, 32'h2001, 2'd2, 32'd0), 1'b1);
    checkOutput("sub_rd_word", 64'(aRespMsg), 64'(mkResp(3'd0, 8'h03, 2'd0, 2'd0, 32'h1122ab44)));
    applyStimulus(0, 1'b1, mkReq(3'd5, 8'h07, 32'h2000, 2'd0, 32'hffffffff), 1'b1);
    checkOutput("sub_rd_half", 64'(aRespMsg), 64'(mkResp(3'd0, 8'h04, 2'd0, 2'd2, 32'h000022ab)));
    applyStimulus(0, 1'b1, mkReq(3'd0, 8'h08, 32'h2000, 2'd0, 32'd0), 1'b1);
    checkOutput("bad_type", 64'(aRespMsg), 64'(mkResp(3'd5, 8'h07, 2'b11, 2'd0, 32'd0)));
    applyStimulus(0, 1'b1, mkReq(3'd1, 8'h09, 32'd65540, 2'd0, 32'hcafef00d), 1'b1);
    checkOutput("bad_type_nowrite", 64'(aRespMsg), 64'(mkResp(3'd0, 8'h08, 2'd0, 2'd0, 32'h1122ab44)));
    applyStimulus(0, 1'b1, mkReq(3'd0, 8'h0a, 32'h4, 2'd0, 32'd0), 1'b1);
    checkOutput("wrap_w", 64'(aRespMsg), 64'(mkResp(3'd1, 8'h09, 2'd0, 2'd0, 32'd0)));
    applyStimulus(0, 1'b1, mkReq(3'd2, 8'h0b, 32'hfffe, 2'd0, 32'h44332211), 1'b1);
    checkOutput("wrap_rd", 64'(aRespMsg), 64'(mkResp(3'd0, 8'h0a, 2'd0, 2'd0, 32'hcafef00d)));
    applyStimulus(0, 1'b1, mkReq(3'd0, 8'h0c, 32'h0, 2'd2, 32'd0), 1'b1);
    checkOutput("init_w", 64'(aRespMsg), 64'(mkResp(3'd2, 8'h0b, 2'd0, 2'd0, 32'd0)));
    applyStimulus(0, 1'b1, mkReq(3'd0, 8'h0d, 32'hffff, 2'd3, 32'd0), 1'b1);
    checkOutput("wrap_top_w", 64'(aRespMsg), 64'(mkResp(3'd0, 8'h0c, 2'd0, 2'd2, 32'h00004433)));
    applyStimulus(0, 1'b0, idle, 1'b1);
    checkOutput("wrap_top_rd", 64'(aRespMsg), 64'(mkResp(3'd0, 8'h0d, 2'd0, 2'd3, 32'h00443322)));
    applyStimulus(0, 1'b0, idle, 1'b1);
    checkOutput("a_drained", 64'(aRespVal), 64'(1'b0));

    // Latency 3: 8 writes then 8 reads back-to-back, one response per cycle from T+3.
    for (int k = 0; k < 16; k++) begin
      if (k < 8) expQ[k] = mkResp(3'd1, 8'(k), 2'd0, 2'd0, 32'd0);
      else       expQ[k] = mkResp(3'd0, 8'(8'h10 + k - 8), 2'd0, 2'd0, 32'hA000_0000 + 32'(k - 8));
    end
    for (int c = 0; c < 20; c++) begin
      if (c < 8)
        applyStimulus(1, 1'b1, mkReq(3'd1, 8'(c), 32'h3000 + 32'(4 * c), 2'd0, 32'hA000_0000 + 32'(c)), 1'b1);
      else if (c < 16)
        applyStimulus(1, 1'b1, mkReq(3'd0, 8'(8'h10 + c - 8), 32'h3000 + 32'(4 * (c - 8)), 2'd0, 32'd0), 1'b1);
      else
        applyStimulus(1, 1'b0, idle, 1'b1);
      if (c < 16) checkOutput("tp_rdy", 64'(bReqRdy), 64'(1'b1));
      checkOutput("tp_val", 64'(bRespVal), 64'(c >= 3 && c < 19));
      if (c >= 3 && c < 19) checkOutput("tp_msg", 64'(bRespMsg), 64'(expQ[c - 3]));
    end

    // Backpressure: four accepts then stall with the head held stable.
    nextIdx = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1, 1'b1, rdReq(nextIdx), 1'b0);
      checkOutput("bp_rdy", 64'(bReqRdy), 64'(c < 4));
      checkOutput("bp_val", 64'(bRespVal), 64'(c >= 3));
      if (c >= 3) checkOutput("bp_msg_stable", 64'(bRespMsg), 64'(rdExp(0)));
      if (bReqRdy) nextIdx++;
    end
    for (int r = 0; r < 10; r++) begin
      applyStimulus(1, r <= 5, (r <= 5) ? rdReq(nextIdx) : idle, 1'b1);
      checkOutput("drain_rdy", 64'(bReqRdy), 64'(r >= 1));
      checkOutput("drain_val", 64'(bRespVal), 64'(r <= 8));
      if (r <= 8) checkOutput("drain_msg", 64'(bRespMsg), 64'(rdExp(r)));
      if (r <= 5 && bReqRdy) nextIdx++;
    end

    // Reset with three responses pending; a write in the reset cycle must be dropped.
    applyStimulus(1, 1'b1, mkReq(3'd1, 8'h30, 32'h4000, 2'd0, 32'h5a5a1234), 1'b0);
    applyStimulus(1, 1'b1, mkReq(3'd0, 8'h31, 32'h3000, 2'd0, 32'd0), 1'b0);
    applyStimulus(1, 1'b1, mkReq(3'd0, 8'h32, 32'h3004, 2'd0, 32'd0), 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bReqMsg = mkReq(3'd1, 8'h33, 32'h4000, 2'd0, 32'hffffffff);
    @(negedge clk);
    checkOutput("pre_rst_val", 64'(bRespVal), 64'(1'b1));
    checkOutput("pre_rst_msg", 64'(bRespMsg), 64'(mkResp(3'd1, 8'h30, 2'd0, 2'd0, 32'd0)));
    @(posedge clk);
    #1;
    reset = 1'b0; bReqVal = 1'b0; bRespRdy = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_val", 64'(bRespVal), 64'(1'b0));
    checkOutput("mid_rst_rdy", 64'(bReqRdy), 64'(1'b1));
    checkOutput("mid_rst_msg", 64'(bRespMsg), 64'd0);
    for (int c = 5; c < 10; c++) begin
      applyStimulus(1, c == 5, (c == 5) ? mkReq(3'd0, 8'h34, 32'h4000, 2'd0, 32'd0) : idle, 1'b1);
      checkOutput("post_rst_val", 64'(bRespVal), 64'(c == 8));
      if (c == 8)
        checkOutput("post_rst_data", 64'(bRespMsg), 64'(mkResp(3'd0, 8'h34, 2'd0, 2'd0, 32'h5a5a1234)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/test_mem_responder.md
Name: test_mem_responder

Overview:
- Behavioural memory that services the processor's instruction and data memory ports.
- Accepts mem_req_4B_t messages on a val/rdy request stream and performs the read or write against an internal byte-addressed array.
- Returns mem_resp_4B_t messages in order on a val/rdy response stream after a programmable minimum latency.
- One instance per port (imem, dmem) in the processor test harness; the same block backs integration tests and cache-less simulation.

Parameters:
- p_mem_nbytes, 65536: array size in bytes; power of two, at least 16.
- p_latency, 1: minimum cycles from request accept to response valid; legal range 1..15.
- p_depth, 4: in-flight response entries; at least 2; must be at least p_latency+1 for one-per-cycle throughput.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- reqstream_val  in  1  request valid
- reqstream_rdy  out  1  request ready
- reqstream_msg  in  mem_req_4B_t  type_[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]
- respstream_val  out  1  response valid
- respstream_rdy  in  1  response ready
- respstream_msg  out  mem_resp_4B_t  type_, opaque, test[1:0], len, data[31:0]

Interface (already decided): one clock; reset is synchronous and active-high; ports named clk and reset.

Behaviour:
- Accept occurs in a cycle where reqstream_val && reqstream_rdy. reqstream_rdy = !full; it does not depend combinationally on respstream_rdy.
- Memory access happens in the accept cycle:
  - Write/init data is committed at the clock edge ending the accept cycle.
  - Read data is sampled in the accept cycle, so a read accepted the cycle after a write to the same address returns the new data.
- Address and length decode:
  - Byte index = addr mod p_mem_nbytes; addresses wrap, no error.
  - len 0 means 4 bytes; len 1/2/3 means 1/2/3 bytes, taken from data[7:0] upward and written starting at the byte index. Unwritten bytes are unchanged.
  - Read returns the len bytes starting at the byte index in data LSBs; upper bytes are zero. Accesses may be unaligned; the byte index wraps modulo the array size.
- Request types:
  - READ (0) returns data as above.
  - WRITE (1) and INIT (2) write as above; response data = 0.
  - Any other type: no array update, response data = 0, test = 2'b11.
- Response fields: opaque, type_ and len are echoed; test = 0 for legal types.
- Response FIFO:
  - Depth p_depth; each entry holds the response plus a 4-bit countdown loaded with p_latency-1 on enqueue.
  - All nonzero countdowns decrement every cycle, including under backpressure.
  - respstream_val = !empty && head countdown == 0. Dequeue occurs on respstream_val && respstream_rdy.
- Latency: a request accepted in cycle T into an empty FIFO gives respstream_val=1 in cycle T+p_latency.
- Ordering: responses are strictly in request order. A younger entry never bypasses a stalled head.
- Simultaneous enqueue and dequeue when full: rdy is still 0, because full is registered. Enqueue and dequeue in the same cycle when not full leaves the count unchanged.
- Backpressure: respstream_msg and respstream_val stay stable while val=1 && rdy=0.
- Reset (including mid-operation):
  - Clears FIFO pointers, count and countdowns; in-flight responses are discarded.
  - Outputs after reset: reqstream_rdy=1, respstream_val=0, respstream_msg=0.
  - Array contents are not cleared. Writes already committed persist; a request presented in the reset cycle is not accepted.

Decomposition:
- Shared package:
  - Request type constants: c_mem_req_read=0, c_mem_req_write=1, c_mem_req_init=2.
  - len-to-bytecount function.
  - Test-code constant c_mem_resp_bad_type=2'b11.
  - The mem_req_4B_t/mem_resp_4B_t structs stay in the existing mem-msgs package.
- Sub-module test_mem_delay_queue: parameterised-depth FIFO of mem_resp_4B_t with per-entry countdown, full/empty flags and head-ready output. The top level holds the array, decode and byte-lane logic.

Test Plan:
- Basic write then read, p_latency=1:
  - WRITE addr=0x1000 len=0 data=0xdeadbeef opaque=0x05, then READ addr=0x1000 len=0 opaque=0x06.
  - Required: responses in cycles T+1 and T+2; second response has data=0xdeadbeef, opaque=0x06, test=0.
- Subword access: WRITE addr=0x2001 len=1 data=0xab over the word 0x11223344 at 0x2000, then READ 0x2000 len=0 -> data=0x1122ab44. READ 0x2001 len=2 -> data=0x000022ab.
- Latency and throughput, p_latency=3, p_depth=4: 8 back-to-back reads with respstream_rdy=1 -> first val at T+3, then one response per cycle, in order, reqstream_rdy never drops.
- Backpressure: respstream_rdy=0 for 10 cycles while issuing reads -> exactly p_depth accepts, then reqstream_rdy=0; msg stable while val=1. Releasing rdy drains entries in order, and each drained entry frees a slot that accepts one new request.
- Illegal type and wrap: type_=5 -> test=2'b11, data=0, array unchanged. WRITE addr=p_mem_nbytes+4 then READ addr=4 -> same data.
- Mid-stream reset: reset asserted with 3 responses pending -> next cycle respstream_val=0, reqstream_rdy=1. A subsequent read of an address written before reset returns the written data.
